// File: rtl/speculative_ghr_ckpt.sv
// Speculative global history register with a circular checkpoint buffer for
// in-flight branches. Optional performance counters are enabled by SPEC_GHR_PERF_EN.
package global_parameters;
    parameter int GLOBAL_HISTORY_WIDTH = 8;
endpackage

module speculative_ghr_ckpt #(
    parameter int HIST_WIDTH = global_parameters::GLOBAL_HISTORY_WIDTH,
    parameter int CKPT_DEPTH = 8,
    parameter int TAG_WIDTH  = $clog2(CKPT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    input  logic                  pred_taken,
    output logic                  pred_ready,
    output logic [TAG_WIDTH-1:0]  pred_tag,
    input  logic                  resolve_valid,
    input  logic [TAG_WIDTH-1:0]  resolve_tag,
    input  logic                  resolve_mispredict,
    input  logic                  resolve_taken,
    input  logic                  retire_valid,
    input  logic                  flush,
    output logic [HIST_WIDTH-1:0] spec_ghr_out,
    output logic [HIST_WIDTH-1:0] arch_ghr_out,
    output logic [TAG_WIDTH:0]    occupancy,
    output logic                  empty,
    output logic                  full
`ifdef SPEC_GHR_PERF_EN
    ,
    output logic [31:0]           mispredict_count,
    output logic [31:0]           squash_count
`endif
);

    localparam logic [TAG_WIDTH:0] DEPTH_CNT = (TAG_WIDTH+1)'(CKPT_DEPTH);

    logic [HIST_WIDTH-1:0] spec_q, arch_q;
    logic [TAG_WIDTH-1:0]  head_q, tail_q;
    logic [TAG_WIDTH:0]    occ_q;
    // Only the low HIST_WIDTH-1 bits of the saved history survive a recovery shift.
    logic [HIST_WIDTH-2:0] ckpt_hist_q [CKPT_DEPTH];
    logic [CKPT_DEPTH-1:0] ckpt_dir_q;

    logic [TAG_WIDTH-1:0]  res_offset;
    logic                  res_live;
    logic                  do_mispredict;
    logic                  do_retire;
    logic                  do_predict;
    logic                  retire_dir;
    logic [TAG_WIDTH:0]    mis_keep;
    logic [TAG_WIDTH:0]    retire_dec;
    logic [TAG_WIDTH:0]    occ_d;

    assign empty        = (occ_q == '0);
    assign full         = (occ_q == DEPTH_CNT);
    assign pred_ready   = !full && !flush && !(resolve_valid && resolve_mispredict);
    assign pred_tag     = tail_q;
    assign spec_ghr_out = spec_q;
    assign arch_ghr_out = arch_q;
    assign occupancy    = occ_q;

    always_comb begin
        res_offset    = resolve_tag - head_q;
        res_live      = ({1'b0, res_offset} < occ_q);
        do_mispredict = resolve_valid && resolve_mispredict && res_live && !flush;
        do_retire     = retire_valid && !empty && !flush;
        do_predict    = pred_valid && pred_ready;
        retire_dir    = (do_mispredict && (resolve_tag == head_q)) ? resolve_taken
                                                                   : ckpt_dir_q[head_q];
        mis_keep      = {1'b0, res_offset} + (TAG_WIDTH+1)'(1);
        retire_dec    = (TAG_WIDTH+1)'(do_retire);
        occ_d         = occ_q;
        if (flush)
            occ_d = '0;
        else if (do_mispredict)
            occ_d = mis_keep - retire_dec;
        else if (do_predict)
            occ_d = occ_q + (TAG_WIDTH+1)'(1) - retire_dec;
        else
            occ_d = occ_q - retire_dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_q     <= '0;
            arch_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            ckpt_dir_q <= '0;
            for (int i = 0; i < CKPT_DEPTH; i++)
                ckpt_hist_q[i] <= '0;
        end else begin
            occ_q <= occ_d;
            if (flush) begin
                spec_q <= arch_q;
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (do_mispredict) begin
                    spec_q                  <= {ckpt_hist_q[resolve_tag], resolve_taken};
                    ckpt_dir_q[resolve_tag] <= resolve_taken;
                    tail_q                  <= resolve_tag + TAG_WIDTH'(1);
                end else if (do_predict) begin
                    ckpt_hist_q[tail_q] <= spec_q[HIST_WIDTH-2:0];
                    ckpt_dir_q[tail_q]  <= pred_taken;
                    spec_q              <= {spec_q[HIST_WIDTH-2:0], pred_taken};
                    tail_q              <= tail_q + TAG_WIDTH'(1);
                end
                if (do_retire) begin
                    arch_q <= {arch_q[HIST_WIDTH-2:0], retire_dir};
                    head_q <= head_q + TAG_WIDTH'(1);
                end
            end
        end
    end

`ifdef SPEC_GHR_PERF_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic [31:0] squash_amt;

    always_comb begin
        squash_amt = '0;
        if (flush)
            squash_amt = 32'(occ_q);
        else if (do_mispredict)
            squash_amt = 32'(occ_q - mis_keep);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_count <= '0;
            squash_count     <= '0;
        end else begin
            if (do_mispredict)
                mispredict_count <= sat_add(mispredict_count, 32'd1);
            squash_count <= sat_add(squash_count, squash_amt);
        end
    end
`endif

endmodule

// File: tb/tb_speculative_ghr_ckpt.sv
// Directed bench for speculative_ghr_ckpt at HIST_WIDTH=8, CKPT_DEPTH=4.
// Expected values are hand-derived from the history/checkpoint rules.
module tb_speculative_ghr_ckpt;

    logic       clk = 1'b0;
    logic       rst;
    logic       pred_valid, pred_taken, pred_ready;
    logic [1:0] pred_tag;
    logic       resolve_valid, resolve_mispredict, resolve_taken;
    logic [1:0] resolve_tag;
    logic       retire_valid, flush;
    logic [7:0] spec_ghr_out, arch_ghr_out;
    logic [2:0] occupancy;
    logic       empty, full;
`ifdef SPEC_GHR_PERF_EN
    logic [31:0] mispredict_count, squash_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    speculative_ghr_ckpt #(.HIST_WIDTH(8), .CKPT_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ready(pred_ready), .pred_tag(pred_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_mispredict(resolve_mispredict), .resolve_taken(resolve_taken),
        .retire_valid(retire_valid), .flush(flush),
        .spec_ghr_out(spec_ghr_out), .arch_ghr_out(arch_ghr_out),
        .occupancy(occupancy), .empty(empty), .full(full)
`ifdef SPEC_GHR_PERF_EN
        , .mispredict_count(mispredict_count), .squash_count(squash_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pred_valid = 0; pred_taken = 0;
        resolve_valid = 0; resolve_tag = 0; resolve_mispredict = 0; resolve_taken = 0;
        retire_valid = 0; flush = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (spec_ghr_out !== 8'h00) begin n_fail++; $display("FAIL reset_spec: got %h want %h", spec_ghr_out, 8'h00); end
        n_checks++; if (arch_ghr_out !== 8'h00) begin n_fail++; $display("FAIL reset_arch: got %h want %h", arch_ghr_out, 8'h00); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (pred_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", pred_ready); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_checks++; if (pred_tag !== 2'd0) begin n_fail++; $display("FAIL reset_tag: got %0d want 0", pred_tag); end
    endtask

    // T,N,T from reset: spec 1 -> 2 -> 5, tags 0,1,2
    task automatic test_predict();
        pred_valid = 1; pred_taken = 1; #1;
        n_checks++; if (pred_tag !== 2'd0) begin n_fail++; $display("FAIL pred_tag0: got %0d want 0", pred_tag); end
        tick();
        n_checks++; if (spec_ghr_out !== 8'h01) begin n_fail++; $display("FAIL pred_latency: got %h want %h", spec_ghr_out, 8'h01); end
        pred_taken = 0; #1;
        n_checks++; if (pred_tag !== 2'd1) begin n_fail++; $display("FAIL pred_tag1: got %0d want 1", pred_tag); end
        tick();
        pred_taken = 1; #1;
        n_checks++; if (pred_tag !== 2'd2) begin n_fail++; $display("FAIL pred_tag2: got %0d want 2", pred_tag); end
        tick();
        pred_valid = 0; pred_taken = 0;
        n_checks++; if (spec_ghr_out !== 8'b0000_0101) begin n_fail++; $display("FAIL pred_spec: got %b want %b", spec_ghr_out, 8'b0000_0101); end
        n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL pred_occ: got %0d want 3", occupancy); end
    endtask

    // Tag 1 held spec=01 before its prediction; recovery gives {01[6:0],1}=03
    task automatic test_mispredict();
        resolve_valid = 1; resolve_tag = 2'd1; resolve_mispredict = 1; resolve_taken = 1;
        pred_valid = 1; pred_taken = 0; #1;
        n_checks++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL mis_ready: got %b want 0", pred_ready); end
        tick();
        clear_inputs();
        n_checks++; if (spec_ghr_out !== 8'b0000_0011) begin n_fail++; $display("FAIL mis_spec: got %b want %b", spec_ghr_out, 8'b0000_0011); end
        n_checks++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL mis_occ: got %0d want 2", occupancy); end
        n_checks++; if (pred_tag !== 2'd2) begin n_fail++; $display("FAIL mis_tag: got %0d want 2", pred_tag); end
        resolve_valid = 1; resolve_tag = 2'd2; resolve_mispredict = 1; resolve_taken = 0;
        tick();
        clear_inputs();
        n_checks++; if (spec_ghr_out !== 8'b0000_0011) begin n_fail++; $display("FAIL stale_spec: got %b want %b", spec_ghr_out, 8'b0000_0011); end
        n_checks++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL stale_occ: got %0d want 2", occupancy); end
    endtask

    task automatic test_retire();
        retire_valid = 1;
        tick();
        tick();
        n_checks++; if (arch_ghr_out !== 8'b0000_0011) begin n_fail++; $display("FAIL retire_arch: got %b want %b", arch_ghr_out, 8'b0000_0011); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL retire_empty: got %b want 1", empty); end
        tick();
        retire_valid = 0;
        n_checks++; if (arch_ghr_out !== 8'b0000_0011) begin n_fail++; $display("FAIL retire_when_empty: got %b want %b", arch_ghr_out, 8'b0000_0011); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL retire_occ: got %0d want 0", occupancy); end
        resolve_valid = 1; resolve_tag = 2'd2; resolve_mispredict = 1; resolve_taken = 0;
        tick();
        clear_inputs();
        n_checks++; if (spec_ghr_out !== 8'b0000_0011) begin n_fail++; $display("FAIL resolve_empty_spec: got %b want %b", spec_ghr_out, 8'b0000_0011); end
    endtask

    task automatic test_full();
        do_reset();
        pred_valid = 1; pred_taken = 1;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
        n_checks++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", pred_ready); end
        tick();
        tick();
        n_checks++; if (spec_ghr_out !== 8'h0F) begin n_fail++; $display("FAIL full_spec_held: got %h want %h", spec_ghr_out, 8'h0F); end
        n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL full_occ: got %0d want 4", occupancy); end
        retire_valid = 1;
        tick();
        retire_valid = 0;
        n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL full_retire_occ: got %0d want 3", occupancy); end
        n_checks++; if (pred_tag !== 2'd0) begin n_fail++; $display("FAIL full_wrap_tag: got %0d want 0", pred_tag); end
        n_checks++; if (arch_ghr_out !== 8'h01) begin n_fail++; $display("FAIL full_retire_arch: got %h want %h", arch_ghr_out, 8'h01); end
        tick();
        pred_valid = 0;
        n_checks++; if (spec_ghr_out !== 8'h1F) begin n_fail++; $display("FAIL stalled_accept_spec: got %h want %h", spec_ghr_out, 8'h1F); end
        n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL stalled_accept_occ: got %0d want 4", occupancy); end
    endtask

    task automatic test_flush();
        do_reset();
        pred_valid = 1; pred_taken = 1; tick();
        pred_taken = 0; tick();
        pred_taken = 1; tick();
        flush = 1; #1;
        n_checks++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", pred_ready); end
        tick();
        clear_inputs();
        n_checks++; if (spec_ghr_out !== 8'h00) begin n_fail++; $display("FAIL flush_spec: got %h want %h", spec_ghr_out, 8'h00); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        n_checks++; if (pred_tag !== 2'd0) begin n_fail++; $display("FAIL flush_tag: got %0d want 0", pred_tag); end
    endtask

    // Continues from flushed state: predict+retire together, then mispredict at head with retire
    task automatic test_back_to_back();
        pred_valid = 1; pred_taken = 1; tick();
        pred_taken = 0; retire_valid = 1; tick();
        clear_inputs();
        n_checks++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL b2b_occ: got %0d want 1", occupancy); end
        n_checks++; if (arch_ghr_out !== 8'h01) begin n_fail++; $display("FAIL b2b_arch: got %h want %h", arch_ghr_out, 8'h01); end
        n_checks++; if (spec_ghr_out !== 8'h02) begin n_fail++; $display("FAIL b2b_spec: got %h want %h", spec_ghr_out, 8'h02); end
        resolve_valid = 1; resolve_tag = 2'd1; resolve_mispredict = 1; resolve_taken = 1; retire_valid = 1;
        tick();
        clear_inputs();
        n_checks++; if (arch_ghr_out !== 8'h03) begin n_fail++; $display("FAIL head_mis_arch: got %h want %h", arch_ghr_out, 8'h03); end
        n_checks++; if (spec_ghr_out !== 8'h03) begin n_fail++; $display("FAIL head_mis_spec: got %h want %h", spec_ghr_out, 8'h03); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL head_mis_occ: got %0d want 0", occupancy); end
        n_checks++; if (pred_tag !== 2'd2) begin n_fail++; $display("FAIL head_mis_tag: got %0d want 2", pred_tag); end
    endtask

    task automatic test_async_reset();
        pred_valid = 1; pred_taken = 1; tick();
        tick();
        #2;
        rst = 1;
        #1;
        n_checks++; if (spec_ghr_out !== 8'h00) begin n_fail++; $display("FAIL areset_spec: got %h want %h", spec_ghr_out, 8'h00); end
        n_checks++; if (arch_ghr_out !== 8'h00) begin n_fail++; $display("FAIL areset_arch: got %h want %h", arch_ghr_out, 8'h00); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL areset_occ: got %0d want 0", occupancy); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL areset_empty: got %b want 1", empty); end
        n_checks++; if (pred_tag !== 2'd0) begin n_fail++; $display("FAIL areset_tag: got %0d want 0", pred_tag); end
        clear_inputs();
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_predict();
        test_mispredict();
        test_retire();
        test_full();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/speculative_ghr_ckpt.md
Name: speculative_ghr_ckpt

Overview:
- Speculative global history register with a checkpoint buffer for in-flight branches, in-order retirement and mispredict recovery.
- Front-end shifts speculative history at predict time. Each prediction returns a tag.
- Back-end resolves branches by tag and retires them in order.
- Architectural history tracks retired outcomes only. A flush restores the speculative history from the architectural history.

Parameters:
- HIST_WIDTH, default global_parameters::GLOBAL_HISTORY_WIDTH: history bits; must be >=2.
- CKPT_DEPTH, default 8: maximum in-flight branches; must be a power of 2 and >=2.
- TAG_WIDTH, default $clog2(CKPT_DEPTH): checkpoint tag width; derived, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pred_valid  in  1  predicted branch presented
- pred_taken  in  1  predicted direction (1 = Taken)
- pred_ready  out  1  prediction accepted this cycle when high with pred_valid
- pred_tag  out  TAG_WIDTH  tag allocated to the current prediction (combinational, equals tail)
- resolve_valid  in  1  branch resolution
- resolve_tag  in  TAG_WIDTH  tag being resolved
- resolve_mispredict  in  1  predicted direction was wrong
- resolve_taken  in  1  actual direction
- retire_valid  in  1  retire oldest in-flight branch
- flush  in  1  discard all in-flight branches
- spec_ghr_out  out  HIST_WIDTH  speculative history, bit 0 = newest
- arch_ghr_out  out  HIST_WIDTH  retired history, bit 0 = newest
- occupancy  out  TAG_WIDTH+1  in-flight count
- empty, full  out  1  occupancy==0 / occupancy==CKPT_DEPTH

Behaviour:
- Reset: spec, arch, head, tail and occupancy are 0; empty=1, full=0, pred_ready=1. All checkpoint entries are cleared.
- Reset mid-operation discards all state immediately.
- Buffer: circular. Each entry holds the pre-prediction spec history plus a direction bit. Head and tail wrap modulo CKPT_DEPTH.
- pred_ready = !full && !flush && !(resolve_valid && resolve_mispredict).
- Predict (pred_valid && pred_ready):
  - entry[tail] <= {spec, pred_taken}
  - spec <= {spec[HIST_WIDTH-2:0], pred_taken}
  - tail++, occupancy++
  - 1-cycle latency to spec_ghr_out.
- Resolve, correct prediction: no state change.
- Resolve, mispredict with a live tag t (t within [head, tail) modulo depth):
  - spec <= {entry[t].hist[HIST_WIDTH-2:0], resolve_taken}
  - entry[t].dir <= resolve_taken
  - tail <= t+1, squashing all younger entries
  - occupancy <= ((t-head) mod CKPT_DEPTH)+1, minus 1 if a retire occurs the same cycle
- Resolve with a non-live tag is ignored. This includes any resolve while empty.
- Retire (retire_valid && !empty):
  - arch <= {arch[HIST_WIDTH-2:0], entry[head].dir}
  - head++, occupancy--
  - If a mispredict targets head in the same cycle, the retired direction is resolve_taken. Both effects apply: the entry retires and occupancy becomes 0.
- Retire while empty is ignored.
- Simultaneous predict and retire: both apply; occupancy is unchanged.
- Priority order: rst > flush > mispredict > predict. Retire is orthogonal, except that flush suppresses it.
- Flush: spec <= arch; head = tail = occupancy = 0; a same-cycle predict is not accepted.
- Full: pred_ready=0; a held pred_valid is stalled, not dropped.

Optional Feature:
- Macro SPEC_GHR_PERF_EN.
- When defined:
  - Adds output ports mispredict_count [31:0] and squash_count [31:0].
  - mispredict_count increments on each accepted live-tag mispredict.
  - squash_count adds the number of younger entries discarded by a mispredict, i.e. old occupancy minus new occupancy before retire adjustment. Flush adds the flushed occupancy.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan (HIST_WIDTH=8, CKPT_DEPTH=4):
- Reset, no stimulus -> spec=arch=8'h00, empty=1, full=0, pred_ready=1, occupancy=0.
- Predict T,N,T on consecutive cycles -> tags 0,1,2; spec=8'b0000_0101; occupancy=3.
- Predict T x4 then hold pred_valid -> full=1, pred_ready=0; 5th prediction stalled; spec=8'h0F held until a retire, then accepted with tag 0.
- After T,N,T, mispredict tag 1 with taken=1 -> spec=8'b0000_0011, occupancy=2, next pred_tag=2; tag-2 resolve afterwards ignored.
- Continue the previous case, retire twice -> arch=8'b0000_0011, empty=1.
- Three in flight with arch=8'h00, assert flush with pred_valid=1 -> spec=8'h00, occupancy=0, prediction not accepted. Assert rst mid-predict -> all outputs return to reset values asynchronously.
